// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher for 128/192/256-bit keys: one round per clock, on-chip key schedule.
// Optional CBC chaining (iv_load/iv_in ports) is enabled by defining AES_DEC_CBC_EN.
module aes_decrypt_iter #(
  parameter int KEY_BITS = 192
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
`ifdef AES_DEC_CBC_EN
  input  logic                iv_load,
  input  logic [127:0]        iv_in,
`endif
  output logic                busy
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEYEXP, DECRYPT, HOLD} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31-8*i -: 8] = SBOX[2047 - 8*int'(x[31-8*i -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[2047 - 8*int'(s[127-8*i -: 8]) -: 8];
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4], x2 [4], x4 [4], x8 [4], m9 [4], mb [4], md [4], me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  state_t        state, state_nxt;
  logic [31:0]   w [NW];
  logic [5:0]    widx;
  logic [2:0]    kmod;
  logic [7:0]    rcon;
  logic [3:0]    rnd;
  logic          fin;
  logic [127:0]  st;
  logic          accept, load_go, exp_done;
  logic [5:0]    rbase;
  logic [127:0]  rk_cur, rk_last, dec_core, chain_xor;
  logic [31:0]   prev, temp, new_word;
`ifdef AES_DEC_CBC_EN
  logic [127:0]  chain, shadow;
  assign chain_xor = chain;
`else
  assign chain_xor = '0;
`endif

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // out_valid/out_data hold until taken, and in_ready never depends combinationally on in_valid.
  assign in_ready = key_ready && (state == IDLE);
  assign busy     = (state == KEYEXP) || (state == DECRYPT);
  assign accept   = in_valid && in_ready;
  // A block accepted in IDLE wins over a simultaneous key_load, which is then dropped.
  assign load_go  = key_load && ((state == KEYEXP) || (state == HOLD) || ((state == IDLE) && !accept));
  assign exp_done = (widx == 6'(NW));
  assign rbase    = {rnd, 2'b00};
  assign rk_cur   = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
  assign rk_last  = {w[4*NR], w[4*NR+1], w[4*NR+2], w[4*NR+3]};
  assign dec_core = add_round_key(inv_sub_bytes(inv_shift_rows(st)), rk_cur);

  always_comb begin
    prev = w[widx - 6'd1];
    temp = prev;
    if (kmod == 3'd0) temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if ((NK == 8) && (kmod == 3'd4)) temp = sub_word(prev);
    new_word = w[widx - 6'(NK)] ^ temp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DECRYPT;
               else if (load_go) state_nxt = KEYEXP;
      KEYEXP:  if (!load_go && exp_done) state_nxt = (out_valid && !out_ready) ? HOLD : IDLE;
      DECRYPT: if (fin) state_nxt = HOLD;
      HOLD:    if (load_go) state_nxt = KEYEXP;
               else if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      st        <= '0;
      rnd       <= '0;
      fin       <= 1'b0;
      widx      <= '0;
      kmod      <= '0;
      rcon      <= 8'h01;
`ifdef AES_DEC_CBC_EN
      chain     <= '0;
      shadow    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (load_go) begin
        key_ready <= 1'b0;
        widx      <= 6'(NK);
        kmod      <= '0;
        rcon      <= 8'h01;
      end else if (state == KEYEXP) begin
        if (!exp_done) begin
          widx <= widx + 6'd1;
          kmod <= (kmod == 3'(NK-1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
        end else begin
          key_ready <= 1'b1;
        end
      end
      if (accept) begin
        st  <= add_round_key(in_data, rk_last);
        rnd <= 4'(NR-1);
        fin <= 1'b0;
`ifdef AES_DEC_CBC_EN
        shadow <= in_data;
`endif
      end else if (state == DECRYPT) begin
        // fin marks the cycle after the last round: out_data is already final, now publish it.
        if (fin) begin
          out_valid <= 1'b1;
          fin       <= 1'b0;
`ifdef AES_DEC_CBC_EN
          chain     <= shadow;
`endif
        end else if (rnd != 4'd0) begin
          st  <= inv_mix_columns(dec_core);
          rnd <= rnd - 4'd1;
        end else begin
          out_data <= dec_core ^ chain_xor;
          fin      <= 1'b1;
        end
      end
`ifdef AES_DEC_CBC_EN
      if (iv_load && ((state == IDLE) || (state == HOLD))) chain <= iv_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (load_go) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[KEY_BITS-1-32*j -: 32];
    end else if ((state == KEYEXP) && !exp_done) begin
      w[widx] <= new_word;
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors for all key sizes, backpressure, key reload and reset abort.
module tb_aes_decrypt_iter;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] K192B = 192'hf0e1d2c3b4a5968778695a4b3c2d1e0f1122334455667788;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         key_load, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
  logic [191:0] key_in;
  logic [127:0] in_data, out_data;
  logic         key_load_a, key_ready_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] key_in_a, in_data_a, out_data_a;
  logic         key_load_b, key_ready_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [255:0] key_in_b;
  logic [127:0] in_data_b, out_data_b;
`ifdef AES_DEC_CBC_EN
  logic         iv_load;
  logic [127:0] iv_in;
  logic [127:0] chain_m = '0;
`endif

  aes_decrypt_iter #(.KEY_BITS(192)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_DEC_CBC_EN
    .iv_load(iv_load), .iv_in(iv_in),
`endif
    .busy(busy));

  aes_decrypt_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load_a), .key_in(key_in_a), .key_ready(key_ready_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
`ifdef AES_DEC_CBC_EN
    .iv_load(1'b0), .iv_in(128'h0),
`endif
    .busy(busy_a));

  aes_decrypt_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load_b), .key_in(key_in_b), .key_ready(key_ready_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
`ifdef AES_DEC_CBC_EN
    .iv_load(1'b0), .iv_in(128'h0),
`endif
    .busy(busy_b));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: expected event did not occur", nm);
  endtask

  // Scoreboard for the 192-bit instance
  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic         ov_d = 1'b0;
  int           hs_cyc = 0;
  int           acc_last = 0;
  int           kl_cyc = 0;
  logic [127:0] last_exp;

  function automatic logic [127:0] exp_for();
`ifdef AES_DEC_CBC_EN
    logic [127:0] r;
    r = PT ^ chain_m;
    chain_m = C192;
    return r;
`else
    return PT;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_last = cyc + 1;
      end
      if (out_valid && !ov_d) begin
        if (acc_q.size() == 0) fail("latency192_orphan");
        else check_int("latency192", cyc - acc_q.pop_front(), 13);
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc + 1;
        if (exp_q.size() == 0) fail("data192_unexpected");
        else check("data192", out_data, exp_q.pop_front());
      end
    end
    ov_d = out_valid;
  end

  // Scoreboards for the 128/256-bit instances (out_ready held high there)
  logic [127:0] exp_qa[$], exp_qb[$];
  int           acc_a = 0, acc_b = 0;
  logic         side_done = 1'b0;

  always @(negedge clk) begin
    if (rst_n && !side_done) begin
      if (in_valid_a && in_ready_a) acc_a = cyc + 1;
      if (in_valid_b && in_ready_b) acc_b = cyc + 1;
      if (out_valid_a && out_ready_a) begin
        if (exp_qa.size() == 0) fail("data128_unexpected");
        else begin
          check("data128", out_data_a, exp_qa.pop_front());
          check_int("latency128", cyc - acc_a, 11);
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (exp_qb.size() == 0) fail("data256_unexpected");
        else begin
          check("data256", out_data_b, exp_qb.pop_front());
          check_int("latency256", cyc - acc_b, 15);
        end
      end
    end
  end

  task automatic load_key(input logic [191:0] k);
    @(posedge clk); #1;
    key_load = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    key_load = 1'b0;
    kl_cyc = cyc;
  endtask

  task automatic wait_key(input int exp_lat, input string nm);
    int n = 0;
    while (!key_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) fail(nm);
    else check_int(nm, cyc - kl_cyc, exp_lat);
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) fail(nm);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [127:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    last_exp = exp_for();
    exp_q.push_back(last_exp);
    wait_accept("accept192");
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_int(nm, exp_q.size(), 0);
  endtask

  task automatic check_outs_zero(input string nm);
    check_int({nm, "_key_ready"}, int'(key_ready), 0);
    check_int({nm, "_in_ready"}, int'(in_ready), 0);
    check_int({nm, "_out_valid"}, int'(out_valid), 0);
    check_int({nm, "_busy"}, int'(busy), 0);
    check({nm, "_out_data"}, out_data, 128'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 128/256-bit instances: key expansion timing and one FIPS vector each
  initial begin
    int n;
    int ra, rb;
    key_load_a = 1'b0; key_in_a = '0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    key_load_b = 1'b0; key_in_b = '0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    @(posedge rst_n);
    @(posedge clk); #1;
    key_load_a = 1'b1; key_in_a = K128;
    key_load_b = 1'b1; key_in_b = K256;
    @(posedge clk); #1;
    key_load_a = 1'b0; key_load_b = 1'b0;
    ra = 0; rb = 0;
    for (int e0 = cyc, k = 0; k < 80; k++) begin
      @(negedge clk);
      if (key_ready_a && ra == 0) ra = cyc - e0;
      if (key_ready_b && rb == 0) rb = cyc - e0;
    end
    check_int("keyexp128", ra, 41);
    check_int("keyexp256", rb, 53);
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_data_a = C128; exp_qa.push_back(PT);
    in_valid_b = 1'b1; in_data_b = C256; exp_qb.push_back(PT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready_a && in_ready_b) && n < 50);
    if (!(in_ready_a && in_ready_b)) fail("accept128_256");
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int("drain128", exp_qa.size(), 0);
    check_int("drain256", exp_qb.size(), 0);
    side_done = 1'b1;
  end

  initial begin
    int n;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef AES_DEC_CBC_EN
    iv_load = 1'b0; iv_in = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Key expansion timing and first vector
    load_key(K192);
    check_int("busy_keyexp", int'(busy), 1);
    check_int("in_ready_keyexp", int'(in_ready), 0);
    wait_key(47, "keyexp192");
`ifdef AES_DEC_CBC_EN
    @(posedge clk); #1;
    iv_load = 1'b1; iv_in = IV;
    @(posedge clk); #1;
    iv_load = 1'b0;
    chain_m = IV;
`endif
    send(C192);
    drain("drain_first");

    // Backpressure with a second block waiting
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(C192);
    in_valid = 1'b1;
    in_data = C192;
    begin
      logic [127:0] held;
      held = last_exp;
      exp_q.push_back(exp_for());
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) fail("hold_out_valid");
      repeat (20) begin
        @(negedge clk);
        check("hold_data", out_data, held);
        check_int("hold_in_ready", int'(in_ready), 0);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("reaccept");
    check_int("reaccept_gap", acc_last - hs_cyc, 1);
    drain("drain_backpressure");

    // key_load mid-expansion restarts; key_load during decryption is ignored
    load_key(K192B);
    repeat (20) @(posedge clk);
    #1;
    check_int("key_ready_mid_exp", int'(key_ready), 0);
    load_key(K192);
    wait_key(47, "keyexp_restart");
    send(C192);
    repeat (3) @(posedge clk);
    #1;
    key_load = 1'b1;
    key_in = K192B;
    @(posedge clk); #1;
    key_load = 1'b0;
    check_int("busy_decrypt", int'(busy), 1);
    check_int("key_ready_kept", int'(key_ready), 1);
    drain("drain_ignored_load");
    send(C192);
    drain("drain_old_schedule");

    // Asynchronous reset during decryption
    n = 0;
    while (!side_done && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (!side_done) fail("side_done");
    send(C192);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs_zero("abort");
    exp_q.delete();
    acc_q.delete();
`ifdef AES_DEC_CBC_EN
    chain_m = '0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = C192;
    exp_q.push_back(exp_for());
    repeat (5) begin
      @(negedge clk);
      check_int("post_reset_key_ready", int'(key_ready), 0);
      check_int("post_reset_in_ready", int'(in_ready), 0);
    end
    load_key(K192);
    wait_key(47, "keyexp_after_reset");
    wait_accept("accept_after_reset");
    drain("drain_after_reset");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES inverse cipher, parametrised for 128/192/256-bit keys. Generational successor to the team's fully unrolled combinational AES-192 decryption layer.
- One round per clock, a sequential on-chip key schedule, and valid/ready handshakes on the input and output sides.
- Sits between the ciphertext ingress stream and the plaintext consumer.
- Reuses the existing inv_shift_rows, inv_subByte, inv_mix_columns and add_round_key blocks.

Parameters:
- KEY_BITS, 192, cipher key length; legal values are 128, 192 and 256. Derived values: NK = KEY_BITS/32 and NR = NK+6.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_load  in  1  single-cycle pulse; captures key_in and starts key expansion.
- key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 8] hold FIPS-197 byte 0.
- key_ready  out  1  high when the round-key store holds a complete, valid schedule.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  block accepted on the clock edge where in_valid and in_ready are both high.
- in_data  in  128  ciphertext; bits [127:120] hold byte 0.
- out_valid  out  1  plaintext valid; held until accepted.
- out_ready  in  1  consumer ready.
- out_data  out  128  plaintext; same byte order as in_data.
- busy  out  1  high in the KEYEXP or DECRYPT state.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. key_ready, in_ready, out_valid, busy and out_data all reset to 0. Round-key store contents are don't-care.
- FSM states: IDLE, KEYEXP, DECRYPT, HOLD.
- Key storage: 4*(NR+1) 32-bit words. The key_load cycle writes words w[0..NK-1] from key_in.
- KEYEXP:
  - Produces one word per cycle, w[i] for i = NK .. 4*(NR+1)-1, using standard RotWord/SubWord/Rcon.
  - Rcon sequence is 01000000, 02000000, ... 36000000 in the top byte.
  - For NK=8 only, apply SubWord when i mod 8 = 4.
  - Cycle count is 4*(NR+1)-NK: 40 / 46 / 52 for key sizes 128 / 192 / 256.
  - key_ready goes high on the cycle after the last word is written. The FSM then enters IDLE, or HOLD if out_valid is still pending.
- key_load handling:
  - key_load in IDLE or HOLD: clears key_ready and enters KEYEXP. A pending output stays valid and unchanged.
  - key_load in KEYEXP: restarts expansion with the new key.
  - key_load in DECRYPT: ignored.
- in_ready = key_ready & (state==IDLE). It is combinational from registered state, so it is low while out_valid is pending.
- DECRYPT:
  - Acceptance cycle T registers state = in_data XOR rk[NR]; round counter r = NR-1.
  - Cycles T+1 .. T+NR-1 each perform: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[r]); then r decrements.
  - Final cycle T+NR performs: out_data = InvSubBytes(InvShiftRows(state)) XOR rk[0]. out_valid rises at T+NR+1.
  - Latency from acceptance to out_valid: 11 / 13 / 15 cycles for key sizes 128 / 192 / 256.
  - Here rk[r] means w[4r .. 4r+3], with w[4r] in bits [127:96].
- HOLD: out_valid=1 and out_data is stable. When out_valid & out_ready, out_valid drops next cycle and the FSM returns to IDLE. A new block can be accepted one cycle later (no same-cycle pass-through).
- No ciphertext is accepted while key_ready=0; in_valid asserted in that condition is simply stalled.
- Asserting rst_n low in any state aborts immediately. Partial state and schedule are discarded, and key_ready=0.

Optional Feature:
- AES_DEC_CBC_EN:
  - When defined, add ports iv_load (in, 1) and iv_in (in, 128). A 128-bit chain register is loaded from iv_in on iv_load in IDLE or HOLD; it resets to 0.
  - The final output becomes (inverse-cipher result) XOR chain. On acceptance, the accepted in_data is captured into a shadow register, which is copied into chain when out_valid rises. Latency is unchanged.
  - iv_load in DECRYPT or KEYEXP is ignored.
- When undefined: pure ECB; no extra ports or registers.

Test Plan:
- KEY_BITS=192, key 000102030405060708090a0b0c0d0e0f1011121314151617, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> key_ready 47 cycles after key_load; out_data 00112233445566778899aabbccddeeff; out_valid exactly 13 cycles after acceptance.
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff after 11 cycles. KEY_BITS=256, key 00..1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 15 cycles.
- out_ready held low 20 cycles with a second in_valid pending -> out_data stable, in_ready=0 throughout; second block accepted the cycle after out_valid drops.
- key_load pulsed mid-KEYEXP with a different key, then key_load during DECRYPT -> the KEYEXP pulse restarts the full cycle count; the DECRYPT pulse is ignored and the current block decrypts with the old schedule.
- rst_n pulsed low at round 5 -> all outputs 0 asynchronously; after reset, key_ready=0 and in_ready=0 until a new key_load completes.
- AES_DEC_CBC_EN: IV 000102030405060708090a0b0c0d0e0f, 192-bit key above, two blocks C1, C2 -> P1 = D(C1) XOR IV and P2 = D(C2) XOR C1, checked against the reference model.
